// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C slave word transmitter.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_ACK_WAIT   = 2'd2,
    ST_ACK_SAMPLE = 2'd3
  } i2c_state_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/i2c_slave_tx_word_if.sv
// Host/bus signal bundle for i2c_slave_tx_word. scl_oe exists only when
// I2C_SLAVE_TX_STRETCH_EN is defined.
interface i2c_slave_tx_word_if #(parameter int DATA_WIDTH = 8);
  logic                  go;
  logic [DATA_WIDTH-1:0] data;
  logic                  scl;
  logic                  sda_in;
  logic                  sda_oe;
  logic                  busy;
  logic                  finish;
  logic                  ack;
`ifdef I2C_SLAVE_TX_STRETCH_EN
  logic                  scl_oe;

  modport master (output go, data, scl, sda_in,
                  input  sda_oe, busy, finish, ack, scl_oe);
  modport slave  (input  go, data, scl, sda_in,
                  output sda_oe, busy, finish, ack, scl_oe);
`else
  modport master (output go, data, scl, sda_in,
                  input  sda_oe, busy, finish, ack);
  modport slave  (input  go, data, scl, sda_in,
                  output sda_oe, busy, finish, ack);
`endif
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the
// synchronized level. Resets to 1 (idle bus level).
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o =  lvl_o & ~prev_q;
  assign fall_o = ~lvl_o &  prev_q;

endmodule

// File: rtl/i2c_slave_tx_word.sv
// I2C slave transmitter: shifts one DATA_WIDTH word MSB-first onto SDA, then
// samples the master ACK. Optional SCL stretching via I2C_SLAVE_TX_STRETCH_EN.
module i2c_slave_tx_word
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic               clk,
  input logic               rst_n,
  i2c_slave_tx_word_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise_unused, sda_fall_unused;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.scl),
    .lvl_o  (scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.sda_in),
    .lvl_o  (sda_lvl),
    .rise_o (sda_rise_unused),
    .fall_o (sda_fall_unused)
  );

  i2c_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, sh_nxt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  ack_q, ack_d;
  logic                  finish_q, finish_d;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sda_oe_d = sda_oe_q;
    ack_d    = ack_q;
    finish_d = 1'b0;
    sh_nxt   = shreg_q << 1;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          shreg_d  = bus.data;
          cnt_d    = CW'(DATA_WIDTH);
          sda_oe_d = ~bus.data[DATA_WIDTH-1];
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (scl_rise && cnt_q != '0) cnt_d = cnt_q - CW'(1);
        // A fall before the first rise belongs to the previous bit; ignore it.
        if (scl_fall) begin
          if (cnt_q == '0) begin
            sda_oe_d = 1'b0;
            state_d  = ST_ACK_WAIT;
          end else if (cnt_q != CW'(DATA_WIDTH)) begin
            shreg_d  = sh_nxt;
            sda_oe_d = ~sh_nxt[DATA_WIDTH-1];
          end
        end
      end
      ST_ACK_WAIT: begin
        if (scl_rise) begin
          ack_d   = ~sda_lvl;
          state_d = ST_ACK_SAMPLE;
        end
      end
      ST_ACK_SAMPLE: begin
        if (scl_fall) begin
          finish_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sda_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sda_oe_q <= sda_oe_d;
      ack_q    <= ack_d;
      finish_q <= finish_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.finish = finish_q;
  assign bus.ack    = ack_q;

`ifdef I2C_SLAVE_TX_STRETCH_EN
  // Hold SCL low after an ACKed word until the host supplies the next one.
  logic scl_oe_q, scl_oe_d;

  always_comb begin
    scl_oe_d = scl_oe_q;
    if (state_q == ST_ACK_SAMPLE && scl_fall)           scl_oe_d = ack_q;
    else if (state_q != ST_IDLE)                        scl_oe_d = 1'b0;
    else if (bus.go || scl_lvl)                         scl_oe_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl_oe_q <= 1'b0;
    else        scl_oe_q <= scl_oe_d;
  end

  assign bus.scl_oe = scl_oe_q;
`else
  logic scl_lvl_unused;
  assign scl_lvl_unused = scl_lvl;
`endif

endmodule

// File: tb/tb_i2c_slave_tx_word.sv
// Directed bench: bit-banged I2C master against 8-, 32- and 1-bit instances.
module tb_i2c_slave_tx_word;

  localparam int HALF = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b0;
  logic        m_sda = 1'b1;
  logic        go    = 1'b0;
  logic [31:0] data  = '0;
  int          sel   = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_slave_tx_word_if #(.DATA_WIDTH(8))  b8  ();
  i2c_slave_tx_word_if #(.DATA_WIDTH(32)) b32 ();
  i2c_slave_tx_word_if #(.DATA_WIDTH(1))  b1  ();

  assign b8.go   = go && (sel == 0);
  assign b32.go  = go && (sel == 1);
  assign b1.go   = go && (sel == 2);
  assign b8.data  = data[7:0];
  assign b32.data = data;
  assign b1.data  = data[0:0];

`ifdef I2C_SLAVE_TX_STRETCH_EN
  assign b8.scl  = m_scl & ~b8.scl_oe;
  assign b32.scl = m_scl & ~b32.scl_oe;
  assign b1.scl  = m_scl & ~b1.scl_oe;
`else
  assign b8.scl  = m_scl;
  assign b32.scl = m_scl;
  assign b1.scl  = m_scl;
`endif
  assign b8.sda_in  = m_sda & ~b8.sda_oe;
  assign b32.sda_in = m_sda & ~b32.sda_oe;
  assign b1.sda_in  = m_sda & ~b1.sda_oe;

  i2c_slave_tx_word #(.DATA_WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  i2c_slave_tx_word #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  i2c_slave_tx_word #(.DATA_WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic s_oe, s_busy, s_fin, s_ack, s_sda;
  always_comb begin
    s_oe = b8.sda_oe; s_busy = b8.busy; s_fin = b8.finish; s_ack = b8.ack; s_sda = b8.sda_in;
    if (sel == 1) begin
      s_oe = b32.sda_oe; s_busy = b32.busy; s_fin = b32.finish; s_ack = b32.ack; s_sda = b32.sda_in;
    end else if (sel == 2) begin
      s_oe = b1.sda_oe; s_busy = b1.busy; s_fin = b1.finish; s_ack = b1.ack; s_sda = b1.sda_in;
    end
  end

  // finish pulses seen, and cycles where busy follows a finish directly
  int   fin_cnt = 0;
  int   b2b_cnt = 0;
  logic fin_prev = 1'b0;
  always @(negedge clk) begin
    if (s_fin) fin_cnt <= fin_cnt + 1;
    if (fin_prev && s_busy) b2b_cnt <= b2b_cnt + 1;
    fin_prev <= s_fin;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [31:0] d);
    data = d;
    go   = 1'b1;
    tick(1);
    go   = 1'b0;
  endtask

  // Clock nbits data bits (sampling SDA mid-high), then optionally the ACK bit.
  task automatic xfer(input int nbits, input bit do_ack, input bit mack,
                      output logic [31:0] got, output logic rel);
    got = '0;
    rel = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      m_scl = 1'b0; tick(HALF);
      m_scl = 1'b1; tick(HALF/2);
      got = {got[30:0], s_sda};
      tick(HALF/2);
    end
    m_scl = 1'b0;
    if (do_ack) begin
      tick(HALF/2);
      m_sda = ~mack;
      tick(HALF/2);
      m_scl = 1'b1; tick(HALF/2);
      rel = (s_oe == 1'b0);
      tick(HALF/2);
      m_scl = 1'b0; tick(2);
      m_sda = 1'b1; tick(HALF);
    end
  endtask

  logic [31:0] g, g2;
  logic        rel;
  int          f0, bb0, n;

  initial begin
    // reset state
    tick(3);
    chk("rst_sda_oe", b8.sda_oe, 0);
    chk("rst_busy",   b8.busy,   0);
    chk("rst_finish", b8.finish, 0);
    chk("rst_ack",    b8.ack,    0);
    rst_n = 1'b1;
    tick(4);

    // A5 with ACK
    sel = 0; f0 = fin_cnt;
    start(32'hA5);
    chk("a5_busy", s_busy, 1);
    chk("a5_msb_oe", s_oe, 0);
    xfer(8, 1, 1, g, rel);
    chk("a5_bits", g[7:0], 8'hA5);
    chk("a5_ack_rel", rel, 1);
    chk("a5_fin", fin_cnt - f0, 1);
    chk("a5_ack", s_ack, 1);
    chk("a5_idle", s_busy, 0);

    // 32-bit NACK
    sel = 1; f0 = fin_cnt;
    start(32'h13579BDF);
    xfer(32, 1, 0, g, rel);
    chk("w32_bits", g, 32'h13579BDF);
    chk("w32_rel", rel, 1);
    chk("w32_fin", fin_cnt - f0, 1);
    chk("w32_ack", s_ack, 0);

    // 1-bit words
    sel = 2; f0 = fin_cnt;
    start(32'h0);
    xfer(1, 1, 1, g, rel);
    chk("w1a_bit", g[0], 0);
    chk("w1a_rel", rel, 1);
    chk("w1a_ack", s_ack, 1);
    start(32'h1);
    xfer(1, 1, 0, g, rel);
    chk("w1b_bit", g[0], 1);
    chk("w1b_ack", s_ack, 0);
    chk("w1_fin", fin_cnt - f0, 2);

    // back-to-back 00 then FF with go held
    sel = 0; f0 = fin_cnt; bb0 = b2b_cnt;
    data = 32'h00; go = 1'b1;
    tick(1);
    data = 32'hFF;
    xfer(8, 1, 1, g, rel);
    go = 1'b0;
    chk("b2b_w0", g[7:0], 8'h00);
    chk("b2b_gap", b2b_cnt - bb0, 1);
    chk("b2b_busy2", s_busy, 1);
    xfer(8, 1, 1, g2, rel);
    chk("b2b_w1", g2[7:0], 8'hFF);
    chk("b2b_fin", fin_cnt - f0, 2);
    tick(2);
    chk("b2b_idle", s_busy, 0);

    // go while busy is ignored
    f0 = fin_cnt;
    start(32'h81);
    fork
      xfer(8, 1, 1, g, rel);
      begin
        tick(40);
        data = 32'h55; go = 1'b1;
        tick(1);
        go = 1'b0;
      end
    join
    chk("busy_go_bits", g[7:0], 8'h81);
    chk("busy_go_fin", fin_cnt - f0, 1);
    chk("busy_go_idle", s_busy, 0);

    // reset mid-word, then resend
    start(32'h3C);
    xfer(6, 0, 0, g, rel);
    tick(HALF);
    chk("rst_pre_bits", g[5:0], 6'b001111);
    chk("rst_pre_oe", s_oe, 1);
    f0 = fin_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_oe", b8.sda_oe, 0);
    chk("rst_async_busy", b8.busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("rst_no_fin", fin_cnt - f0, 0);
    start(32'h3C);
    xfer(8, 1, 1, g, rel);
    chk("rst_resend", g[7:0], 8'h3C);
    chk("rst_resend_fin", fin_cnt - f0, 1);

`ifdef I2C_SLAVE_TX_STRETCH_EN
    start(32'hC3);
    xfer(8, 1, 1, g, rel);
    chk("str_ack", s_ack, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b8.scl_oe) n++;
      tick(1);
    end
    chk("str_hold", n, 20);
    data = 32'h5A; go = 1'b1;
    chk("str_pre_go", b8.scl_oe, 1);
    tick(1);
    go = 1'b0;
    chk("str_release", b8.scl_oe, 0);
    chk("str_msb", b8.sda_oe, 1);
    xfer(8, 1, 0, g, rel);
    chk("str_bits", g[7:0], 8'h5A);
    chk("str_nack_free", b8.scl_oe, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
